// File: rtl/branch_issue_arb_pkg.sv
// Shared types for the branch issue path: issue packet, FU feedback task and arbiter state.
// Also holds the saturating-add helper used by the optional BR_ARB_PERF_EN counters.
package branch_issue_arb_pkg;

  localparam int B_MASK_WIDTH = 4;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } BR_TASK;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } BR_ARB_STATE;

  typedef struct packed {
    logic [B_MASK_WIDTH-1:0] b_mask;
    logic [B_MASK_WIDTH-1:0] b_id;
  } DECODED_VALS;

  typedef struct packed {
    logic [31:0] pc;
    DECODED_VALS decoded_vals;
  } ISSUE_PACKET;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/branch_issue_arb_rr_picker.sv
// Round-robin one-hot selector: grants the first eligible index at or after ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    logic [IW-1:0] idx;
    // NOTE: every output gets a default before the loop, so no path infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    // Walk from the farthest offset back to ptr so the nearest eligible index wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (eligible[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/branch_issue_arb.sv
// Issue arbiter for branch_fu: round-robin grant, one-shot registered issue, squash/clear kill.
// Optional feature macro: BR_ARB_PERF_EN adds saturating perf counter outputs.
module branch_issue_arb
  import branch_issue_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int B_MASK_W = B_MASK_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  ISSUE_PACKET         req_pack [NUM_REQ],
  input  logic                fu_data_ready,
  input  BR_TASK              fu_br_task,
  input  logic [B_MASK_W-1:0] fu_b_id,
  output logic [NUM_REQ-1:0]  grant,
  output ISSUE_PACKET         fu_is_pack,
  output logic                fu_rd_en,
  output logic                stall
`ifdef BR_ARB_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_killed,
  output logic [31:0]         perf_hold_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  BR_ARB_STATE        state_q, state_d;
  logic               run;
  logic [IDX_W-1:0]   rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] kill, eligible;
  logic               resolve, squash, clear;
  logic               held_v, held_kill;
  ISSUE_PACKET        held, load_pack;

  assign resolve = fu_data_ready && (fu_br_task != NOTHING);
  assign squash  = resolve && (fu_br_task == SQUASH);
  assign clear   = resolve && (fu_br_task == CLEAR);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      kill[i] = squash && |(req_pack[i].decoded_vals.b_mask & fu_b_id);
  end

  // Dependent requests are filtered before picking, so a squashed branch is never granted.
  assign eligible = req_valid & ~kill & {NUM_REQ{run && !reset}};

  rr_picker #(.N(NUM_REQ), .IW(IDX_W)) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .gnt      (grant),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    load_pack = req_pack[gnt_idx];
    if (clear)
      load_pack.decoded_vals.b_mask = req_pack[gnt_idx].decoded_vals.b_mask & ~fu_b_id;
  end

  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      rr_ptr  <= '0;
      held_v  <= 1'b0;
      // NOTE: the held packet is reset too because it drives fu_is_pack, which must read zero.
      held    <= '0;
    end else begin
      state_q <= state_d;
      held_v  <= |grant;
      if (|grant) begin
        held   <= load_pack;
        rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (squash) state_d = HOLD;
      HOLD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    run   = (state_q == RUN);
    stall = (state_q == HOLD);
  end

  assign held_kill = squash && |(held.decoded_vals.b_mask & fu_b_id);
  assign fu_rd_en  = held_v && !held_kill;

  // A branch resolving as CLEAR this cycle is retired from the packet the FU captures now.
  always_comb begin
    fu_is_pack = held;
    if (clear)
      fu_is_pack.decoded_vals.b_mask = held.decoded_vals.b_mask & ~fu_b_id;
  end

`ifdef BR_ARB_PERF_EN
  logic [31:0] kill_cnt;

  always_comb begin
    kill_cnt = {31'b0, held_v && held_kill};
    for (int i = 0; i < NUM_REQ; i++)
      kill_cnt = kill_cnt + {31'b0, req_valid[i] && kill[i]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issued      <= '0;
      perf_killed      <= '0;
      perf_hold_cycles <= '0;
    end else begin
      perf_issued      <= sat_add(perf_issued, {31'b0, fu_rd_en});
      perf_killed      <= sat_add(perf_killed, kill_cnt);
      perf_hold_cycles <= sat_add(perf_hold_cycles, {31'b0, stall});
    end
  end
`endif

endmodule

// File: tb/tb_branch_issue_arb.sv
// Directed bench for branch_issue_arb: stimulus pushes expected issues, a negedge monitor scores them.
module tb_branch_issue_arb;
  import branch_issue_arb_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [3:0]              req_valid;
  ISSUE_PACKET             req_pack [4];
  logic                    fu_data_ready;
  BR_TASK                  fu_br_task;
  logic [B_MASK_WIDTH-1:0] fu_b_id;
  logic [3:0]              grant;
  ISSUE_PACKET             fu_is_pack;
  logic                    fu_rd_en;
  logic                    stall;
`ifdef BR_ARB_PERF_EN
  logic [31:0]             perf_issued, perf_killed, perf_hold_cycles;
`endif

  int          checks = 0;
  int          errors = 0;
  ISSUE_PACKET exp_q[$];
  ISSUE_PACKET mon_e;

  always #5 clock = ~clock;

  branch_issue_arb #(.NUM_REQ(4), .B_MASK_W(B_MASK_WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_pack      (req_pack),
    .fu_data_ready (fu_data_ready),
    .fu_br_task    (fu_br_task),
    .fu_b_id       (fu_b_id),
    .grant         (grant),
    .fu_is_pack    (fu_is_pack),
    .fu_rd_en      (fu_rd_en),
    .stall         (stall)
`ifdef BR_ARB_PERF_EN
    ,
    .perf_issued      (perf_issued),
    .perf_killed      (perf_killed),
    .perf_hold_cycles (perf_hold_cycles)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ISSUE_PACKET pkt(input logic [31:0] pc, input logic [3:0] mask);
    ISSUE_PACKET p;
    p = '0;
    p.pc = pc;
    p.decoded_vals.b_mask = mask;
    return p;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic fb(input logic rdy, input BR_TASK t, input logic [3:0] id);
    fu_data_ready = rdy;
    fu_br_task    = t;
    fu_b_id       = id;
  endtask

  // Monitor: every FU issue strobe must match the oldest expected packet.
  always @(negedge clock) begin
    if (fu_rd_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got pc %0h expected no issue", fu_is_pack.pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_pc", 64'(fu_is_pack.pc), 64'(mon_e.pc));
        check("issue_mask", 64'(fu_is_pack.decoded_vals.b_mask), 64'(mon_e.decoded_vals.b_mask));
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) req_pack[i] = '0;
    fb(1'b0, NOTHING, 4'b0000);
    repeat (2) @(posedge clock);
    #2;
    check("reset_grant", 64'(grant), 64'h0);
    check("reset_rd_en", 64'(fu_rd_en), 64'h0);
    check("reset_pack", 64'(fu_is_pack), 64'h0);
    check("reset_stall", 64'(stall), 64'h0);
    reset = 1'b0;

    // Round-robin fairness from reset.
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_pack[i] = pkt(32'hA0 + i, 4'b0000);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_grant", 64'(grant), 64'(4'b0001 << i));
      exp_q.push_back(pkt(32'hA0 + i, 4'b0000));
      next_cycle();
    end
    req_valid = '0;
    #1;
    check("rr_idle_grant", 64'(grant), 64'h0);
    check("rr_last_rd_en", 64'(fu_rd_en), 64'h1);
    next_cycle();

    // Drive pointer to 3, then wrap to index 0.
    check("idle_rd_en", 64'(fu_rd_en), 64'h0);
    req_valid = 4'b0100;
    req_pack[2] = pkt(32'hB2, 4'b0000);
    #1;
    check("ptr3_setup_grant", 64'(grant), 64'(4'b0100));
    exp_q.push_back(pkt(32'hB2, 4'b0000));
    next_cycle();
    req_valid = 4'b0101;
    req_pack[0] = pkt(32'hB0, 4'b0000);
    req_pack[2] = pkt(32'hB3, 4'b0000);
    #1;
    check("wrap_grant", 64'(grant), 64'(4'b0001));
    exp_q.push_back(pkt(32'hB0, 4'b0000));
    next_cycle();
    #1;
    check("after_wrap_grant", 64'(grant), 64'(4'b0100));
    exp_q.push_back(pkt(32'hB3, 4'b0000));
    next_cycle();

    // Squash kills the only requester; HOLD for one cycle.
    req_valid = 4'b0010;
    req_pack[1] = pkt(32'hC1, 4'b0010);
    fb(1'b1, SQUASH, 4'b0010);
    #1;
    check("squash_kill_grant", 64'(grant), 64'h0);
    next_cycle();
    fb(1'b0, NOTHING, 4'b0000);
    req_pack[1] = pkt(32'hD1, 4'b0000);
    #1;
    check("hold_stall", 64'(stall), 64'h1);
    check("hold_grant", 64'(grant), 64'h0);
    next_cycle();
    #1;
    check("resume_stall", 64'(stall), 64'h0);
    check("resume_grant", 64'(grant), 64'(4'b0010));
    exp_q.push_back(pkt(32'hD1, 4'b0000));
    next_cycle();

    // Held kill: granted packet squashed the cycle it would issue.
    req_valid = 4'b0100;
    req_pack[2] = pkt(32'hE2, 4'b0100);
    #1;
    check("held_kill_grant", 64'(grant), 64'(4'b0100));
    next_cycle();
    req_valid = '0;
    fb(1'b1, SQUASH, 4'b0100);
    #1;
    check("held_kill_rd_en", 64'(fu_rd_en), 64'h0);
    next_cycle();
    fb(1'b0, NOTHING, 4'b0000);
    #1;
    check("held_kill_stall", 64'(stall), 64'h1);
    next_cycle();

    // Squash and grant together: dependent req3 skipped, independent req0 granted.
    check("pre_mix_stall", 64'(stall), 64'h0);
    req_valid = 4'b1001;
    req_pack[3] = pkt(32'hF3, 4'b1000);
    req_pack[0] = pkt(32'hF0, 4'b0000);
    fb(1'b1, SQUASH, 4'b1000);
    #1;
    check("mix_grant", 64'(grant), 64'(4'b0001));
    exp_q.push_back(pkt(32'hF0, 4'b0000));
    next_cycle();
    fb(1'b0, NOTHING, 4'b0000);
    req_valid = '0;
    #1;
    check("mix_stall", 64'(stall), 64'h1);
    check("mix_rd_en", 64'(fu_rd_en), 64'h1);
    next_cycle();

    // CLEAR retires b_id 0001 from the loaded mask.
    req_valid = 4'b0010;
    req_pack[1] = pkt(32'h101, 4'b0011);
    fb(1'b1, CLEAR, 4'b0001);
    #1;
    check("clear_grant", 64'(grant), 64'(4'b0010));
    exp_q.push_back(pkt(32'h101, 4'b0010));
    next_cycle();

    // Squash with b_id outside every mask: nothing killed, still HOLD.
    req_valid = 4'b0100;
    req_pack[2] = pkt(32'h102, 4'b0001);
    fb(1'b1, SQUASH, 4'b1000);
    #1;
    check("nokill_rd_en", 64'(fu_rd_en), 64'h1);
    check("nokill_grant", 64'(grant), 64'(4'b0100));
    exp_q.push_back(pkt(32'h102, 4'b0001));
    next_cycle();
    fb(1'b0, NOTHING, 4'b0000);
    #1;
    check("nokill_stall", 64'(stall), 64'h1);
    check("nokill_hold_grant", 64'(grant), 64'h0);
    next_cycle();

    // Reset during HOLD with a pending issue.
    req_valid = 4'b0010;
    req_pack[1] = pkt(32'h111, 4'b0000);
    fb(1'b1, SQUASH, 4'b0001);
    #1;
    check("pre_reset_grant", 64'(grant), 64'(4'b0010));
    exp_q.push_back(pkt(32'h111, 4'b0000));
    next_cycle();
    fb(1'b0, NOTHING, 4'b0000);
    req_valid = '0;
    reset = 1'b1;
    #1;
    check("pre_reset_stall", 64'(stall), 64'h1);
    next_cycle();
    reset = 1'b0;
    #1;
    check("post_reset_grant", 64'(grant), 64'h0);
    check("post_reset_rd_en", 64'(fu_rd_en), 64'h0);
    check("post_reset_pack", 64'(fu_is_pack), 64'h0);
    check("post_reset_stall", 64'(stall), 64'h0);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_pack[i] = pkt(32'h120 + i, 4'b0000);
    #1;
    check("post_reset_ptr_grant", 64'(grant), 64'(4'b0001));
    exp_q.push_back(pkt(32'h120, 4'b0000));
    next_cycle();
    req_valid = '0;
    repeat (3) next_cycle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_issue_arb.md
# branch_issue_arb

Issue-side arbiter and sequencer for the single `branch_fu`. Selects one ready branch per cycle from `NUM_REQ` reservation-station requesters (round-robin), registers the chosen `ISSUE_PACKET` into the FU with `rd_en`, and consumes the FU's `br_task` feedback. On feedback it kills dependent work: on `SQUASH` it drops in-flight and pending younger branches; on `CLEAR` it retires the resolved `b_id` from held masks. Sits between the RS issue stage and `branch_fu`.

## Interface
- `NUM_REQ`, 4: number of requesters (RS branch slots), ≥2.
- `B_MASK_W`, `` `B_MASK_WIDTH ``: branch-mask / one-hot `b_id` width.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i holds a ready branch.
- `req_pack`  in  ISSUE_PACKET[NUM_REQ]  packets; `decoded_vals.b_mask` is the dependency mask.
- `fu_data_ready`  in  1  `branch_fu.data_ready`.
- `fu_br_task`  in  BR_TASK  `branch_fu.br_task` (NOTHING/CLEAR/SQUASH).
- `fu_b_id`  in  B_MASK_W  one-hot `b_id` of the resolving branch, from `fu_pack.decoded_vals.b_id`.
- `grant`  out  NUM_REQ  one-hot, combinational; requester i frees its slot at the edge.
- `fu_is_pack`  out  ISSUE_PACKET  registered packet to FU.
- `fu_rd_en`  out  1  FU issue strobe.
- `stall`  out  1  high in HOLD state.

## Operation
- States: RUN, HOLD. Reset → RUN.
- `resolve = fu_data_ready && fu_br_task != NOTHING`. `kill_i = resolve && SQUASH && |(req_pack[i].b_mask & fu_b_id)`.
- Eligible i = `req_valid[i] && !kill_i`, and only in RUN. Grant the first eligible index at or after `rr_ptr`, wrapping modulo `NUM_REQ`. No eligible request → `grant = 0`.
- On grant of i: `rr_ptr <= (i+1) mod NUM_REQ`; the held register loads `req_pack[i]` and sets `held_v = 1`. With no grant: `held_v <= 0` (one-shot issue; the FU is never stalled).
- Mask update on load: if `resolve && CLEAR`, the loaded `b_mask` has the `fu_b_id` bit cleared. The same clearing applies to a held packet in the same cycle.
- `fu_rd_en = held_v && !held_kill`, where `held_kill = resolve && SQUASH && |(held.b_mask & fu_b_id)`. A killed held packet never reaches the FU.
- RUN → HOLD on `resolve && SQUASH`. HOLD → RUN after exactly one cycle. During HOLD `grant = 0` and `stall = 1`.
- A SQUASH with `fu_b_id` outside every mask still enters HOLD, but kills nothing.

## Timing
- Reset values: `grant = 0`, `fu_rd_en = 0`, `fu_is_pack = '0`, `stall = 0`, `rr_ptr = 0`, state RUN.
- Grant in cycle t → `fu_rd_en`/`fu_is_pack` valid in t+1 → FU result in t+2. Issue-to-feedback latency is 2 cycles.
- Throughput is 1 branch/cycle in RUN.
- Squash feedback and a grant in the same cycle: the kill check applies to the granted packet before load, so a dependent packet is never granted.
- Reset asserted mid-HOLD or with `held_v` set: next cycle matches the reset values; no pending issue survives.

## Configuration
- `` `BR_ARB_PERF_EN `` defined: adds 32-bit saturating counters `perf_issued`, `perf_killed` and `perf_hold_cycles` as outputs, cleared on reset.
  - `perf_issued`: +1 per `fu_rd_en`.
  - `perf_killed`: +1 per killed request or held packet, counted once per packet per cycle.
  - `perf_hold_cycles`: +1 per HOLD cycle.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Add `BR_ARB_STATE` (RUN/HOLD) to `sys_defs.svh`. `ISSUE_PACKET`, `BR_TASK` and `B_MASK_WIDTH` already live there.
- Sub-module `rr_picker`: parameterised round-robin one-hot selector with inputs `eligible` and `ptr`, outputs `gnt` and `gnt_idx`. Reused by other FU arbiters.

## Test plan
- Round-robin fairness: `req_valid = 4'b1111` held for 4 cycles from reset → grants 0001, 0010, 0100, 1000; `fu_rd_en` high cycles 2–5.
- Pointer wrap: `rr_ptr = 3`, `req_valid = 4'b0101` → grant 0001 (index 0), then `rr_ptr = 1`.
- Squash kill: `fu_br_task = SQUASH`, `fu_b_id = 4'b0010`, `req_pack[1].b_mask = 4'b0010`, `req_valid = 4'b0010` → `grant = 0` that cycle, HOLD with `stall = 1` next cycle, then RUN.
- Held kill: packet with `b_mask = 4'b0100` granted in t; SQUASH with `fu_b_id = 4'b0100` in t+1 → `fu_rd_en = 0` in t+1.
- CLEAR mask update: grant packet with `b_mask = 4'b0011` while CLEAR with `fu_b_id = 4'b0001` → `fu_is_pack.decoded_vals.b_mask = 4'b0010`.
- Reset mid-HOLD: assert `reset` in the HOLD cycle → next cycle all outputs 0, state RUN, `rr_ptr = 0`.
